nes_controller_ports: RTL and testbench

NES_CONTROLLER_PORTS -- requirements
Module: nes_controller_ports

---
 rtl/nes_controller_ports.sv | 75 +++++++
 tb/tb_nes_controller_ports.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/nes_controller_ports.sv
// Two NES controller ports: button synchronizers, strobe-loaded shift registers,
// read-edge advance and the CPU read-data mux for $4016/$4017.
module nes_controller_ports #(
  parameter logic       FILL_BIT = 1'b1,
  parameter logic [7:0] OPEN_BUS = 8'h40
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] out,
  input  logic [1:0] oe,
  input  logic [7:0] buttons1,
  input  logic [7:0] buttons2,
  output logic       serial1,
  output logic       serial2,
  output logic [7:0] rdData,
  output logic       rdValid
);

  localparam int unsigned BTN_W = 8;
  localparam int unsigned PORTS = 2;

  logic [PORTS-1:0][BTN_W-1:0] btn_raw;
  logic [PORTS-1:0][BTN_W-1:0] sync_a;
  logic [PORTS-1:0][BTN_W-1:0] sync_b;
  logic [PORTS-1:0][BTN_W-1:0] shift;
  logic [PORTS-1:0]            oe_prev;
  logic [PORTS-1:0]            advance;
  logic                        strobe;
  logic                        unused_out;

  assign btn_raw    = {buttons2, buttons1};
  assign strobe     = out[0];
  assign unused_out = ^out[2:1];

  // Advance on the rising edge of each read enable (end of the CPU read)
  assign advance = ~oe_prev & oe;

  // Synchronizers, read-enable history and per-port shift registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_a  <= '0;
      sync_b  <= '0;
      shift   <= '0;
      oe_prev <= 2'b11;
    end else begin
      sync_a  <= btn_raw;
      sync_b  <= sync_a;
      oe_prev <= oe;
      for (int p = 0; p < int'(PORTS); p++) begin
        // A reload swallows any advance landing in the same cycle
        if (strobe) begin
          shift[p] <= sync_b[p];
        end else if (advance[p]) begin
          shift[p] <= {FILL_BIT, shift[p][BTN_W-1:1]};
        end
      end
    end
  end

  assign serial1 = shift[0][0];
  assign serial2 = shift[1][0];

  // CPU read mux; port 1 wins when both enables are low
  always_comb begin
    rdData = 8'h00;
    if (!oe[0]) begin
      rdData = {OPEN_BUS[7:1], serial1};
    end else if (!oe[1]) begin
      rdData = {OPEN_BUS[7:1], serial2};
    end
  end

  assign rdValid = ~(oe[0] & oe[1]);

endmodule

// File: tb/tb_nes_controller_ports.sv
// Directed bench for nes_controller_ports: vector table of strobe/read records plus
// hand-written sequences for priority, strobe-held, reload-vs-advance and reset.
module tb_nes_controller_ports;

  logic       clock;
  logic       reset;
  logic [2:0] out;
  logic [1:0] oe;
  logic [7:0] buttons1;
  logic [7:0] buttons2;
  logic       serial1;
  logic       serial2;
  logic [7:0] rdData;
  logic       rdValid;

  int tests;
  int fails;

  nes_controller_ports dut (
    .clock    (clock),
    .reset    (reset),
    .out      (out),
    .oe       (oe),
    .buttons1 (buttons1),
    .buttons2 (buttons2),
    .serial1  (serial1),
    .serial2  (serial2),
    .rdData   (rdData),
    .rdValid  (rdValid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       do_strobe;
    logic [7:0] b1;
    logic [7:0] b2;
    int         port;
    int         len;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_strobe(input logic [7:0] b1, input logic [7:0] b2);
    buttons1 = b1;
    buttons2 = b2;
    repeat (3) tick();
    out = 3'b001;
    repeat (4) tick();
    out = 3'b000;
    tick();
  endtask

  task automatic do_read(input int port, input int len, input logic [7:0] exp, input string name);
    logic ser;
    oe[port] = 1'b0;
    #1;
    ser = (port == 0) ? serial1 : serial2;
    check({name, "_data"}, rdData, exp);
    check({name, "_valid"}, 8'(rdValid), 8'h01);
    check({name, "_serial"}, 8'(ser), 8'(exp[0]));
    repeat (len) tick();
    oe[port] = 1'b1;
    tick();
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    reset    = 1'b0;
    out      = 3'b000;
    oe       = 2'b11;
    buttons1 = 8'h00;
    buttons2 = 8'h00;

    // Row table: optional strobe with given buttons, then one read on a port
    vecs[0]  = '{1'b1, 8'h85, 8'h00, 0, 2,  8'h41};
    vecs[1]  = '{1'b0, 8'h85, 8'h00, 0, 2,  8'h40};
    vecs[2]  = '{1'b0, 8'h85, 8'h00, 0, 2,  8'h41};
    vecs[3]  = '{1'b0, 8'h85, 8'h00, 0, 2,  8'h40};
    vecs[4]  = '{1'b0, 8'h85, 8'h00, 0, 2,  8'h40};
    vecs[5]  = '{1'b0, 8'h85, 8'h00, 0, 2,  8'h40};
    vecs[6]  = '{1'b0, 8'h85, 8'h00, 0, 2,  8'h40};
    vecs[7]  = '{1'b0, 8'h85, 8'h00, 0, 2,  8'h41};
    vecs[8]  = '{1'b0, 8'h85, 8'h00, 0, 2,  8'h41};
    vecs[9]  = '{1'b0, 8'h85, 8'h00, 0, 2,  8'h41};
    vecs[10] = '{1'b0, 8'h85, 8'h00, 0, 2,  8'h41};
    vecs[11] = '{1'b1, 8'h00, 8'h02, 1, 2,  8'h40};
    vecs[12] = '{1'b0, 8'h00, 8'h02, 0, 2,  8'h40};
    vecs[13] = '{1'b0, 8'h00, 8'h02, 1, 2,  8'h41};
    vecs[14] = '{1'b0, 8'h00, 8'h02, 0, 2,  8'h40};
    vecs[15] = '{1'b0, 8'h00, 8'h02, 1, 2,  8'h40};
    vecs[16] = '{1'b1, 8'h01, 8'h00, 0, 12, 8'h41};
    vecs[17] = '{1'b0, 8'h01, 8'h00, 0, 1,  8'h40};

    // Reset state
    #3;
    check("rst_data", rdData, 8'h00);
    check("rst_valid", 8'(rdValid), 8'h00);
    check("rst_serial", {6'd0, serial2, serial1}, 8'h00);
    tick();
    reset = 1'b1;
    repeat (2) tick();
    check("post_rst_data", rdData, 8'h00);
    check("post_rst_valid", 8'(rdValid), 8'h00);

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].do_strobe) do_strobe(vecs[i].b1, vecs[i].b2);
      do_read(vecs[i].port, vecs[i].len, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Both enables low: port 1 priority, then both ports advance together
    do_strobe(8'h01, 8'h02);
    oe = 2'b00;
    #1;
    check("both_low_data", rdData, 8'h41);
    check("both_low_valid", 8'(rdValid), 8'h01);
    repeat (2) tick();
    oe = 2'b11;
    tick();
    check("idle_data", rdData, 8'h00);
    check("idle_valid", 8'(rdValid), 8'h00);
    do_read(0, 2, 8'h40, "both_p1");
    do_read(1, 2, 8'h41, "both_p2");

    // Strobe held high: reads never advance
    buttons1 = 8'h01;
    repeat (3) tick();
    out = 3'b001;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) do_read(0, 2, 8'h41, $sformatf("held_strobe%0d", i));
    out = 3'b110;
    tick();
    do_read(0, 2, 8'h41, "held_after0");
    do_read(0, 2, 8'h40, "held_after1");

    // Reload and advance in the same cycle: reload wins
    do_strobe(8'h03, 8'h00);
    buttons1 = 8'h02;
    repeat (3) tick();
    oe[0] = 1'b0;
    repeat (2) tick();
    oe[0] = 1'b1;
    out   = 3'b001;
    tick();
    out = 3'b000;
    tick();
    check("reload_wins_serial", 8'(serial1), 8'h00);
    do_read(0, 2, 8'h40, "reload_wins0");
    do_read(0, 2, 8'h41, "reload_wins1");

    // Reset mid-sequence, then release with oe idle high
    do_strobe(8'hFF, 8'h00);
    for (int i = 0; i < 3; i++) do_read(0, 2, 8'h41, $sformatf("pre_rst%0d", i));
    check("pre_rst_serial", 8'(serial1), 8'h01);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_serial", 8'(serial1), 8'h00);
    check("mid_rst_data", rdData, 8'h00);
    check("mid_rst_valid", 8'(rdValid), 8'h00);
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) do_read(0, 2, 8'h40, $sformatf("post_rst%0d", i));
    do_read(0, 2, 8'h41, "post_rst_fill");
    do_strobe(8'h85, 8'h00);
    do_read(0, 2, 8'h41, "restart_a");
    do_read(0, 2, 8'h40, "restart_b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
